// File: rtl/ttt_turn_controller.sv
// Turn sequencer for the 3x3 tic-tac-toe datapath: validates keypad moves, owns the
// board register, detects win/draw for the mover and enforces an optional turn timer.
module ttt_turn_controller #(
  parameter bit          FIRST_O      = 1'b0,
  parameter int unsigned TURN_TIMEOUT = 500000000,
  parameter int unsigned TMR_W        = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        key_strobe,
  input  logic [3:0]  key_data,
  output logic [17:0] board,
  output logic        turn_o,
  output logic [1:0]  result,
  output logic        in_game,
  output logic        illegal,
  output logic        timeout,
  output logic [3:0]  move_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_EVAL, S_OVER} state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TURN_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [17:0]      board_q, board_d;
  logic             turn_q, turn_d;
  logic [1:0]       result_q, result_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic             key_valid;
  logic             key_free;
  logic [17:0]      mark_mask;
  logic [8:0]       mine;
  logic             win;

  // Decode the key into a cell, check occupancy and build the mover's mark bit
  always_comb begin
    key_valid = 1'b0;
    key_free  = 1'b0;
    mark_mask = '0;
    mine      = '0;
    for (int k = 1; k <= 9; k++) begin
      mine[k-1] = turn_q ? board_q[19-2*k] : board_q[18-2*k];
      if (key_data == 4'(k)) begin
        key_valid = 1'b1;
        key_free  = (board_q[19-2*k -: 2] == 2'b00);
        if (turn_q) mark_mask[19-2*k] = 1'b1;
        else        mark_mask[18-2*k] = 1'b1;
      end
    end
    win = (&mine[2:0]) | (&mine[5:3]) | (&mine[8:6]) |
          (mine[0] & mine[3] & mine[6]) | (mine[1] & mine[4] & mine[7]) |
          (mine[2] & mine[5] & mine[8]) |
          (mine[0] & mine[4] & mine[8]) | (mine[2] & mine[4] & mine[6]);
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    turn_d    = turn_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    timer_d   = '0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    if (start) begin
      state_d  = S_PLAY;
      board_d  = '0;
      result_d = 2'b00;
      cnt_d    = 4'd0;
      turn_d   = FIRST_O;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (key_strobe) begin
            if (key_valid && key_free) begin
              board_d = board_q | mark_mask;
              cnt_d   = cnt_q + 4'd1;
              state_d = S_EVAL;
            end else begin
              // A rejected key on the final timer cycle still rescues the turn
              illegal_d = 1'b1;
              timer_d   = (TURN_TIMEOUT != 0 && timer_q == TMR_LAST) ? '0 : timer_q;
            end
          end else if (TURN_TIMEOUT != 0) begin
            if (timer_q == TMR_LAST) begin
              turn_d    = ~turn_q;
              timeout_d = 1'b1;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        S_EVAL: begin
          if (win) begin
            result_d = turn_q ? 2'b10 : 2'b01;
            state_d  = S_OVER;
          end else if (cnt_q == 4'd9) begin
            result_d = 2'b11;
            state_d  = S_OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = S_PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      board_q   <= '0;
      turn_q    <= FIRST_O;
      result_q  <= 2'b00;
      cnt_q     <= 4'd0;
      timer_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign board    = board_q;
  assign turn_o   = turn_q;
  assign result   = result_q;
  assign move_cnt = cnt_q;
  assign illegal  = illegal_q;
  assign timeout  = timeout_q;
  assign in_game  = (state_q == S_PLAY) || (state_q == S_EVAL);

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Table-driven bench for ttt_turn_controller: one untimed instance for game rules,
// one instance with an 8-cycle turn timer for the forfeit corner cases.
module tb_ttt_turn_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        key_strobe;
  logic [3:0]  key_data;

  logic [17:0] board,   t_board;
  logic        turn_o,  t_turn_o;
  logic [1:0]  result,  t_result;
  logic        in_game, t_in_game;
  logic        illegal, t_illegal;
  logic        timeout, t_timeout;
  logic [3:0]  move_cnt, t_move_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ttt_turn_controller #(.FIRST_O(1'b0), .TURN_TIMEOUT(0), .TMR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_strobe(key_strobe), .key_data(key_data),
    .board(board), .turn_o(turn_o), .result(result), .in_game(in_game),
    .illegal(illegal), .timeout(timeout), .move_cnt(move_cnt)
  );

  ttt_turn_controller #(.FIRST_O(1'b0), .TURN_TIMEOUT(8), .TMR_W(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start), .key_strobe(key_strobe), .key_data(key_data),
    .board(t_board), .turn_o(t_turn_o), .result(t_result), .in_game(t_in_game),
    .illegal(t_illegal), .timeout(t_timeout), .move_cnt(t_move_cnt)
  );

  typedef struct {
    logic        start;
    logic        strobe;
    logic [3:0]  data;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  result;
    logic        ill;
    logic [3:0]  cnt;
    logic        ingame;
  } vec_t;

  typedef int mv_t[9];

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic st, logic [3:0] d, logic [17:0] b, logic t,
                              logic [1:0] r, logic il, logic [3:0] c, logic ig);
    vec_t v;
    v.start = s;  v.strobe = st; v.data = d;  v.board = b;  v.turn = t;
    v.result = r; v.ill = il;    v.cnt = c;   v.ingame = ig;
    return v;
  endfunction

  function automatic void add(logic s, logic st, logic [3:0] d, logic [17:0] b, logic t,
                              logic [1:0] r, logic il, logic [3:0] c, logic ig);
    vecs.push_back(mk(s, st, d, b, t, r, il, c, ig));
  endfunction

  // Mark mask for cell k: upper bit of the pair for O, lower for X
  function automatic logic [17:0] cm(int k, bit o);
    logic [17:0] m;
    m = '0;
    m[o ? 19-2*k : 18-2*k] = 1'b1;
    return m;
  endfunction

  // A full game from start, X first, no line completed before the last move
  function automatic void add_game(mv_t cells, int n, logic [1:0] fin);
    logic [17:0] b;
    bit          o;
    b = '0;
    add(1, 0, 4'd0, '0, 0, 2'b00, 0, 4'd0, 1);
    for (int i = 0; i < n; i++) begin
      o = (i % 2 == 1);
      b = b | cm(cells[i], o);
      add(0, 1, 4'(cells[i]), b, o, 2'b00, 0, 4'(i+1), 1);
      if (i < n-1) add(0, 0, 4'd0, b, !o, 2'b00, 0, 4'(i+1), 1);
      else         add(0, 0, 4'd0, b, o, fin, 0, 4'(n), 0);
    end
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick(input logic s, input logic st, input logic [3:0] d);
    @(negedge clk);
    start      = s;
    key_strobe = st;
    key_data   = d;
    @(posedge clk);
    #1;
    start      = 1'b0;
    key_strobe = 1'b0;
    key_data   = 4'd0;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check($sformatf("v%0d.board", idx),    32'(board),    32'(v.board));
    check($sformatf("v%0d.turn_o", idx),   32'(turn_o),   32'(v.turn));
    check($sformatf("v%0d.result", idx),   32'(result),   32'(v.result));
    check($sformatf("v%0d.illegal", idx),  32'(illegal),  32'(v.ill));
    check($sformatf("v%0d.move_cnt", idx), 32'(move_cnt), 32'(v.cnt));
    check($sformatf("v%0d.in_game", idx),  32'(in_game),  32'(v.ingame));
    check($sformatf("v%0d.timeout", idx),  32'(timeout),  32'd0);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    tick(v.start, v.strobe, v.data);
    check_output(v, idx);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".board"},    32'(board),      32'd0);
    check({tag, ".turn_o"},   32'(turn_o),     32'd0);
    check({tag, ".result"},   32'(result),     32'd0);
    check({tag, ".move_cnt"}, 32'(move_cnt),   32'd0);
    check({tag, ".in_game"},  32'(in_game),    32'd0);
    check({tag, ".illegal"},  32'(illegal),    32'd0);
    check({tag, ".t_in_game"}, 32'(t_in_game), 32'd0);
    check({tag, ".t_timeout"}, 32'(t_timeout), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    key_strobe = 1'b0;
    key_data   = 4'd0;

    // Keys are ignored in IDLE
    add(0, 1, 4'd5, '0, 0, 2'b00, 0, 4'd0, 0);
    // X wins on the top row
    add_game('{1, 4, 2, 5, 3, 0, 0, 0, 0}, 5, 2'b01);
    add(0, 1, 4'd7, 18'b01_01_01_10_10_00_00_00_00, 0, 2'b01, 0, 4'd5, 0);
    // Start with a simultaneous strobe, then occupied cell and bad codes
    add(1, 1, 4'd5, '0, 0, 2'b00, 0, 4'd0, 1);
    add(0, 1, 4'd1, cm(1, 0), 0, 2'b00, 0, 4'd1, 1);
    add(0, 0, 4'd0, cm(1, 0), 1, 2'b00, 0, 4'd1, 1);
    add(0, 1, 4'd1, cm(1, 0), 1, 2'b00, 1, 4'd1, 1);
    add(0, 0, 4'd0, cm(1, 0), 1, 2'b00, 0, 4'd1, 1);
    add(0, 1, 4'd0, cm(1, 0), 1, 2'b00, 1, 4'd1, 1);
    add(0, 1, 4'd12, cm(1, 0), 1, 2'b00, 1, 4'd1, 1);
    add(0, 0, 4'd0, cm(1, 0), 1, 2'b00, 0, 4'd1, 1);
    // Strobe during EVAL is dropped silently
    add(1, 0, 4'd0, '0, 0, 2'b00, 0, 4'd0, 1);
    add(0, 1, 4'd5, cm(5, 0), 0, 2'b00, 0, 4'd1, 1);
    add(0, 1, 4'd1, cm(5, 0), 1, 2'b00, 0, 4'd1, 1);
    add(0, 0, 4'd0, cm(5, 0), 1, 2'b00, 0, 4'd1, 1);
    // Draw, then a 9th move that completes a line
    add_game('{5, 1, 9, 3, 2, 8, 4, 6, 7}, 9, 2'b11);
    add(0, 1, 4'd1, 18'b10_01_10_01_01_10_01_10_01, 0, 2'b11, 0, 4'd9, 0);
    add_game('{5, 1, 9, 3, 2, 8, 4, 7, 6}, 9, 2'b01);
    // start out of OVER
    add(1, 0, 4'd0, '0, 0, 2'b00, 0, 4'd0, 1);

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

    // Mid-game reset wipes a move that is still in EVAL
    apply_stimulus(mk(0, 1, 4'd5, cm(5, 0), 0, 2'b00, 0, 4'd1, 1), 100);
    apply_stimulus(mk(0, 0, 4'd0, cm(5, 0), 1, 2'b00, 0, 4'd1, 1), 101);
    apply_stimulus(mk(0, 1, 4'd1, cm(5, 0) | cm(1, 1), 1, 2'b00, 0, 4'd2, 1), 102);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    check_reset_values("held_rst");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(mk(1, 0, 4'd0, '0, 0, 2'b00, 0, 4'd0, 1), 103);

    // Turn timer: forfeit after 8 cycles, last-cycle legal and illegal keys rescue the turn
    tick(1, 0, 4'd0);
    for (int e = 1; e <= 33; e++) begin
      if (e == 16 || e == 25) tick(0, 1, 4'd5);
      else                    tick(0, 0, 4'd0);
      check($sformatf("tmr%0d.timeout", e), 32'(t_timeout), 32'((e == 8) || (e == 33)));
      if (e == 8) begin
        check("tmr8.turn_o", 32'(t_turn_o), 32'd1);
        check("tmr8.board",  32'(t_board),  32'd0);
      end
      if (e == 16) begin
        check("tmr16.board",    32'(t_board),    32'(cm(5, 1)));
        check("tmr16.move_cnt", 32'(t_move_cnt), 32'd1);
      end
      if (e == 17) check("tmr17.turn_o", 32'(t_turn_o), 32'd0);
      if (e == 25) begin
        check("tmr25.illegal", 32'(t_illegal), 32'd1);
        check("tmr25.board",   32'(t_board),   32'(cm(5, 1)));
      end
      if (e == 33) check("tmr33.turn_o", 32'(t_turn_o), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
